// File: rtl/reorder_buffer_if.sv
// +----------------------------------------------------------------------------+
// | reorder_buffer_if                                                           |
// | Dispatch, CDB, operand-lookup and retire signals of the reorder buffer.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface reorder_buffer_if #(
  parameter int TAG_W = 4
);
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_is_branch;
  logic             alloc_pred_taken;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             cdb_taken;
  logic [31:0]      cdb_target;

  logic [TAG_W-1:0] q1_tag;
  logic [TAG_W-1:0] q2_tag;
  logic             q1_ready;
  logic             q2_ready;
  logic [31:0]      q1_value;
  logic [31:0]      q2_value;

  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_value;
  logic [TAG_W-1:0] commit_tag;
  logic             jump_wrong;
  logic [31:0]      jump_target;
  logic             rob_empty;

  // Driven by dispatch / RS / CDB / register file side.
  modport master (
    output alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken,
    input  alloc_ready, alloc_tag,
    output cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
    output q1_tag, q2_tag,
    input  q1_ready, q2_ready, q1_value, q2_value,
    input  commit_valid, commit_rd, commit_value, commit_tag,
    input  jump_wrong, jump_target, rob_empty
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken,
    output alloc_ready, alloc_tag,
    input  cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
    input  q1_tag, q2_tag,
    output q1_ready, q2_ready, q1_value, q2_value,
    output commit_valid, commit_rd, commit_value, commit_tag,
    output jump_wrong, jump_target, rob_empty
  );
endinterface

`default_nettype wire

// File: rtl/reorder_buffer.sv
// +----------------------------------------------------------------------------+
// | reorder_buffer                                                              |
// | Circular in-order-retire ROB for the Tomasulo RV32I core.                   |
// | Optional macro ROB_BYPASS_EN: operand lookup forwards the live CDB.         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         rdy,
  reorder_buffer_if.slave   bus
);

  localparam logic [TAG_W:0] c_depth = (TAG_W+1)'(ROB_DEPTH);

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic             r_busy       [ROB_DEPTH];
  logic             r_ready      [ROB_DEPTH];
  logic [4:0]       r_rd         [ROB_DEPTH];
  logic [31:0]      r_value      [ROB_DEPTH];
  logic             r_is_branch  [ROB_DEPTH];
  logic             r_pred_taken [ROB_DEPTH];
  logic             r_taken      [ROB_DEPTH];
  logic [31:0]      r_target     [ROB_DEPTH];

  logic             r_commit_valid;
  logic [4:0]       r_commit_rd;
  logic [31:0]      r_commit_value;
  logic [TAG_W-1:0] r_commit_tag;
  logic             r_jump_wrong;
  logic [31:0]      r_jump_target;

  logic             w_alloc_ready;
  logic             w_commit;
  logic             w_flush;
  logic             w_alloc;
  logic             w_cdb;

  // A same-cycle commit does not free a slot for the allocation at that edge.
  assign w_alloc_ready = (r_count != c_depth);
  assign w_commit      = rdy && r_busy[r_head] && r_ready[r_head];
  assign w_flush       = w_commit && r_is_branch[r_head] &&
                         (r_taken[r_head] != r_pred_taken[r_head]);
  assign w_alloc       = rdy && bus.alloc_valid && w_alloc_ready && !w_flush;
  assign w_cdb         = rdy && bus.cdb_valid && r_busy[bus.cdb_tag] && !w_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc)
        r_tail <= r_tail + 1'b1;
      if (w_commit)
        r_head <= r_head + 1'b1;
      r_count <= r_count + {{TAG_W{1'b0}}, w_alloc} - {{TAG_W{1'b0}}, w_commit};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_busy[i]       <= 1'b0;
        r_ready[i]      <= 1'b0;
        r_rd[i]         <= '0;
        r_value[i]      <= '0;
        r_is_branch[i]  <= 1'b0;
        r_pred_taken[i] <= 1'b0;
        r_taken[i]      <= 1'b0;
        r_target[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (w_flush) begin
          r_busy[i] <= 1'b0;
        end else begin
          // The tail slot is never busy, so allocate and retire never collide.
          if (w_alloc && (r_tail == TAG_W'(i))) begin
            r_busy[i]       <= 1'b1;
            r_ready[i]      <= 1'b0;
            r_rd[i]         <= bus.alloc_rd;
            r_is_branch[i]  <= bus.alloc_is_branch;
            r_pred_taken[i] <= bus.alloc_pred_taken;
          end else if (w_commit && (r_head == TAG_W'(i))) begin
            r_busy[i] <= 1'b0;
          end
          if (w_cdb && (bus.cdb_tag == TAG_W'(i))) begin
            r_ready[i]  <= 1'b1;
            r_value[i]  <= bus.cdb_value;
            r_taken[i]  <= bus.cdb_taken;
            r_target[i] <= bus.cdb_target;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_commit_valid <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_value <= '0;
      r_commit_tag   <= '0;
      r_jump_wrong   <= 1'b0;
      r_jump_target  <= '0;
    end else begin
      r_commit_valid <= w_commit;
      r_jump_wrong   <= w_flush;
      if (w_commit) begin
        r_commit_rd    <= r_rd[r_head];
        r_commit_value <= r_value[r_head];
        r_commit_tag   <= r_head;
      end
      if (w_flush)
        r_jump_target <= r_target[r_head];
    end
  end

  always_comb begin
    bus.q1_ready = r_busy[bus.q1_tag] && r_ready[bus.q1_tag];
    bus.q1_value = r_value[bus.q1_tag];
    bus.q2_ready = r_busy[bus.q2_tag] && r_ready[bus.q2_tag];
    bus.q2_value = r_value[bus.q2_tag];
`ifdef ROB_BYPASS_EN
    if (bus.cdb_valid && (bus.cdb_tag == bus.q1_tag)) begin
      bus.q1_ready = 1'b1;
      bus.q1_value = bus.cdb_value;
    end
    if (bus.cdb_valid && (bus.cdb_tag == bus.q2_tag)) begin
      bus.q2_ready = 1'b1;
      bus.q2_value = bus.cdb_value;
    end
`else
    // Stored state only: a broadcast becomes visible after it is latched.
`endif
  end

  assign bus.alloc_ready  = w_alloc_ready;
  assign bus.alloc_tag    = r_tail;
  assign bus.rob_empty    = (r_count == '0);
  assign bus.commit_valid = r_commit_valid;
  assign bus.commit_rd    = r_commit_rd;
  assign bus.commit_value = r_commit_value;
  assign bus.commit_tag   = r_commit_tag;
  assign bus.jump_wrong   = r_jump_wrong;
  assign bus.jump_target  = r_jump_target;

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// +----------------------------------------------------------------------------+
// | tb_reorder_buffer                                                           |
// | Scoreboard bench for reorder_buffer (retire order, flush, bypass, reset).   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reorder_buffer;

`ifdef ROB_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  typedef struct {
    logic [4:0] rd;
    logic [3:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;

  reorder_buffer_if #(.TAG_W(4)) bus ();

  reorder_buffer #(.ROB_DEPTH(16), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  exp_t        sb [$];
  logic [31:0] mdl_val [16];
  logic [3:0]  m_tail  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Scoreboard: every retire pulse must match the oldest outstanding allocation.
  always @(posedge clk) begin
    #1;
    if (bus.commit_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_commit", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_tag",   {28'd0, bus.commit_tag}, {28'd0, e.tag});
        check("commit_rd",    {27'd0, bus.commit_rd},  {27'd0, e.rd});
        check("commit_value", bus.commit_value, mdl_val[e.tag]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
  endtask

  task automatic drive_alloc(input logic [4:0] rd, input logic br, input logic pred,
                             input bit accept);
    bus.alloc_valid      = 1'b1;
    bus.alloc_rd         = rd;
    bus.alloc_is_branch  = br;
    bus.alloc_pred_taken = pred;
    if (accept) begin
      sb.push_back('{rd: rd, tag: m_tail});
      m_tail = m_tail + 4'd1;
    end
  endtask

  task automatic drive_cdb(input logic [3:0] tag, input logic [31:0] val,
                           input logic taken, input logic [31:0] target);
    bus.cdb_valid  = 1'b1;
    bus.cdb_tag    = tag;
    bus.cdb_value  = val;
    bus.cdb_taken  = taken;
    bus.cdb_target = target;
    mdl_val[tag]   = val;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    sb.delete();
    m_tail = '0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.alloc_valid = 0; bus.alloc_rd = 0; bus.alloc_is_branch = 0; bus.alloc_pred_taken = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0; bus.cdb_taken = 0; bus.cdb_target = 0;
    bus.q1_tag = 0; bus.q2_tag = 0;
    for (int i = 0; i < 16; i++) mdl_val[i] = '0;

    // Reset state
    cyc(); cyc();
    check("rst_alloc_ready",  {31'd0, bus.alloc_ready},  32'd1);
    check("rst_alloc_tag",    {28'd0, bus.alloc_tag},    32'd0);
    check("rst_rob_empty",    {31'd0, bus.rob_empty},    32'd1);
    check("rst_commit_valid", {31'd0, bus.commit_valid}, 32'd0);
    check("rst_jump_wrong",   {31'd0, bus.jump_wrong},   32'd0);
    rst = 1'b1;
    cyc();

    // Single allocate / CDB / commit
    drive_alloc(5'd5, 1'b0, 1'b0, 1'b1);
    cyc(); idle();
    check("t1_not_empty", {31'd0, bus.rob_empty}, 32'd0);
    drive_cdb(4'd0, 32'h1234, 1'b0, 32'd0);
    cyc(); idle();
    check("t1_no_early_commit", {31'd0, bus.commit_valid}, 32'd0);
    cyc();
    check("t1_commit_pulse", {31'd0, bus.commit_valid}, 32'd1);
    check("t1_empty_again",  {31'd0, bus.rob_empty},    32'd1);
    cyc();
    check("t1_pulse_once",   {31'd0, bus.commit_valid}, 32'd0);

    // Out-of-order completion, in-order retire
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_alloc(5'(i + 7), 1'b0, 1'b0, 1'b1);
      cyc();
    end
    idle();
    for (int i = 2; i >= 0; i--) begin
      drive_cdb(4'(i), 32'hC0 + 32'(i), 1'b0, 32'd0);
      cyc();
    end
    idle();
    check("t2_wait_head", {31'd0, bus.commit_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t2_seq_valid", {31'd0, bus.commit_valid}, 32'd1);
      check("t2_seq_tag",   {28'd0, bus.commit_tag},   32'(i));
    end
    cyc();
    check("t2_done", {31'd0, bus.commit_valid}, 32'd0);

    // Full buffer, ignored allocation, wrap-around
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_alloc(5'(i + 1), 1'b0, 1'b0, 1'b1);
      cyc();
    end
    idle();
    check("t3_full_ready", {31'd0, bus.alloc_ready}, 32'd0);
    drive_alloc(5'd9, 1'b0, 1'b0, 1'b0);
    cyc(); idle();
    check("t3_17th_ignored", {28'd0, bus.alloc_tag}, 32'd0);
    drive_cdb(4'd0, 32'hA0, 1'b0, 32'd0);
    cyc(); idle();
    drive_alloc(5'd29, 1'b0, 1'b0, 1'b0);
    drive_cdb(4'd1, 32'hA1, 1'b0, 32'd0);
    cyc(); idle();
    check("t3_no_early_free_tag", {28'd0, bus.alloc_tag},   32'd0);
    check("t3_slot_freed",        {31'd0, bus.alloc_ready}, 32'd1);
    drive_alloc(5'd31, 1'b0, 1'b0, 1'b1);
    cyc(); idle();
    check("t3_wrap_tag_next",  {28'd0, bus.alloc_tag},   32'd1);
    check("t3_alloc_commit",   {31'd0, bus.alloc_ready}, 32'd1);
    drive_alloc(5'd30, 1'b0, 1'b0, 1'b1);
    cyc(); idle();
    check("t3_full_again", {31'd0, bus.alloc_ready}, 32'd0);
    check("t3_tail",       {28'd0, bus.alloc_tag},   32'd2);
    for (int i = 2; i < 18; i++) begin
      drive_cdb(4'(i % 16), 32'hB00 + 32'(i), 1'b0, 32'd0);
      cyc();
    end
    idle();
    for (int k = 0; k < 40 && !bus.rob_empty; k++) cyc();
    cyc();
    check("t3_drained", {31'd0, bus.rob_empty}, 32'd1);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Branch mispredict flush
    do_reset();
    drive_alloc(5'd1, 1'b1, 1'b0, 1'b1); cyc();
    drive_alloc(5'd2, 1'b0, 1'b0, 1'b1); cyc();
    drive_alloc(5'd3, 1'b0, 1'b0, 1'b1); cyc();
    idle();
    drive_cdb(4'd1, 32'h11, 1'b0, 32'd0); cyc();
    drive_cdb(4'd0, 32'h8, 1'b1, 32'h100); cyc();
    drive_alloc(5'd4, 1'b0, 1'b0, 1'b0);
    drive_cdb(4'd2, 32'h22, 1'b0, 32'd0);
    cyc(); idle();
    check("t4_jump_wrong",  {31'd0, bus.jump_wrong},   32'd1);
    check("t4_jump_target", bus.jump_target,           32'h100);
    check("t4_br_commit",   {31'd0, bus.commit_valid}, 32'd1);
    sb.delete();
    m_tail = '0;
    check("t4_empty",     {31'd0, bus.rob_empty}, 32'd1);
    check("t4_alloc_tag", {28'd0, bus.alloc_tag}, 32'd0);
    bus.q2_tag = 4'd2;
    #1;
    check("t4_cdb_dropped", {31'd0, bus.q2_ready}, 32'd0);
    cyc();
    check("t4_jump_once", {31'd0, bus.jump_wrong}, 32'd0);
    cyc(); cyc();

    // Operand lookup, with and without CDB bypass
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_alloc(5'(i + 10), 1'b0, 1'b0, 1'b1);
      cyc();
    end
    idle();
    bus.q1_tag = 4'd3;
    bus.q2_tag = 4'd2;
    drive_cdb(4'd3, 32'hAB, 1'b0, 32'd0);
    #1;
    check("t5_q1_same_cycle", {31'd0, bus.q1_ready}, {31'd0, c_byp});
    check("t5_q2_not_ready",  {31'd0, bus.q2_ready}, 32'd0);
    cyc(); idle();
    check("t5_q1_next_ready", {31'd0, bus.q1_ready}, 32'd1);
    check("t5_q1_next_value", bus.q1_value,          32'hAB);
    drive_cdb(4'd0, 32'h55, 1'b0, 32'd0);
    cyc(); idle();
    cyc();
    drive_alloc(5'd20, 1'b0, 1'b0, 1'b1);
    cyc(); idle();

    // Asynchronous reset mid-stream with four busy entries
    rst = 1'b0;
    #1;
    check("t6_commit_value", bus.commit_value,          32'd0);
    check("t6_commit_tag",   {28'd0, bus.commit_tag},   32'd0);
    check("t6_commit_rd",    {27'd0, bus.commit_rd},    32'd0);
    check("t6_alloc_tag",    {28'd0, bus.alloc_tag},    32'd0);
    check("t6_rob_empty",    {31'd0, bus.rob_empty},    32'd1);
    check("t6_jump_target",  bus.jump_target,           32'd0);
    sb.delete();
    m_tail = '0;
    cyc();
    rst = 1'b1;
    cyc();
    drive_cdb(4'd1, 32'h77, 1'b0, 32'd0);
    cyc(); idle();
    for (int i = 0; i < 4; i++) cyc();
    check("t6_still_empty", {31'd0, bus.rob_empty}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
